// File: rtl/des_perm_pkg.sv
// Shared types, DES IP/FP tables and the per-block permutation function
// used by the des_perm_pipe engine.
package des_perm_pkg;

    typedef enum logic {
        PERM_IP = 1'b0,
        PERM_FP = 1'b1
    } perm_mode_e;

    // 1-based DES bit numbers; entry i names the source bit of output bit i
    localparam int IP_TABLE [0:63] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TABLE [0:63] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    // FP first swaps the halves (undoing the last round's L/R swap), then permutes
    function automatic logic [0:63] perm64(input logic [0:63] blk, input logic mode);
        logic [0:63] src;
        logic [0:63] res;
        logic [5:0]  idx;
        if (mode == PERM_FP) begin
            src = {blk[32:63], blk[0:31]};
        end else begin
            src = blk;
        end
        res = 64'd0;
        for (int i = 0; i < 64; i++) begin
            if (mode == PERM_FP) begin
                idx = 6'(FP_TABLE[i] - 1);
            end else begin
                idx = 6'(IP_TABLE[i] - 1);
            end
            res[i] = src[idx];
        end
        return res;
    endfunction

endpackage

// File: rtl/des_perm_stage.sv
// One valid/ready register stage carrying a permuted beat and its mode.
module des_perm_stage
    import des_perm_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [0:WIDTH-1] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] out_data,
    output logic             out_mode
);

    logic             valid_q, valid_d;
    logic [0:WIDTH-1] data_q, data_d;
    logic             mode_q, mode_d;
    logic             load_s;

    // Load when empty or when the held beat leaves this cycle
    always_comb begin
        load_s  = !valid_q || out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        mode_d  = mode_q;
        if (load_s) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
                mode_d = in_mode;
            end else begin
                data_d = data_q;
                mode_d = mode_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_mode  = mode_q;

endmodule

// File: rtl/des_perm_pipe.sv
// Pipelined DES IP/FP block-permutation engine, LANES blocks per beat.
// Define DES_PERM_SKID_EN to register in_ready behind a 2-entry input skid buffer.
module des_perm_pipe
    import des_perm_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int STAGES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [0:64*LANES-1] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_mode,
    output logic [0:64*LANES-1] out_data,
    output logic [0:32*LANES-1] out_l,
    output logic [0:32*LANES-1] out_r,
    output logic                busy
);

    localparam int W = 64 * LANES;

    logic [0:W-1]      src_data_s;
    logic              src_mode_s;
    logic              src_valid_s;
    logic [0:W-1]      perm_data_s;
    logic [0:W-1]      chain_data_s  [0:STAGES];
    logic              chain_mode_s  [0:STAGES];
    logic              chain_valid_s [0:STAGES];
    logic [STAGES-1:0] v_s;
    logic [STAGES:0]   ready_s;
    logic              all_full_s;

`ifdef DES_PERM_SKID_EN
    logic [0:W-1] skid_data_q [0:1];
    logic [0:W-1] skid_data_d [0:1];
    logic [1:0]   skid_mode_q, skid_mode_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         in_ready_q, in_ready_d;
    logic         push_s, pop_s;

    // Skid FIFO bookkeeping; in_ready is precomputed from the next occupancy
    always_comb begin
        push_s      = in_valid && in_ready_q;
        pop_s       = (cnt_q != 2'd0) && ready_s[0];
        skid_data_d = skid_data_q;
        skid_mode_d = skid_mode_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push_s) begin
            skid_data_d[wr_ptr_q] = in_data;
            skid_mode_d[wr_ptr_q] = in_mode;
            wr_ptr_d              = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        in_ready_d = (cnt_d != 2'd2);
    end

    // Skid FIFO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_q[0] <= '0;
            skid_data_q[1] <= '0;
            skid_mode_q    <= 2'b00;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            cnt_q          <= 2'd0;
            in_ready_q     <= 1'b1;
        end else begin
            skid_data_q <= skid_data_d;
            skid_mode_q <= skid_mode_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign src_valid_s = (cnt_q != 2'd0);
    assign src_data_s  = skid_data_q[rd_ptr_q];
    assign src_mode_s  = skid_mode_q[rd_ptr_q];
    assign in_ready    = in_ready_q;
`else
    assign src_valid_s = in_valid;
    assign src_data_s  = in_data;
    assign src_mode_s  = in_mode;
    assign in_ready    = ready_s[0];
`endif

    // Permutation is pure wiring ahead of the stage-0 register
    always_comb begin
        perm_data_s = '0;
        for (int k = 0; k < LANES; k++) begin
            perm_data_s[64*k +: 64] = perm64(src_data_s[64*k +: 64], src_mode_s);
        end
    end

    // Ready of stage s: downstream accepts, or some stage at or after s has a hole
    always_comb begin
        ready_s    = '0;
        all_full_s = 1'b1;
        ready_s[STAGES] = out_ready;
        for (int s = 0; s < STAGES; s++) begin
            all_full_s = 1'b1;
            for (int t = s; t < STAGES; t++) begin
                all_full_s = all_full_s && v_s[t];
            end
            ready_s[s] = out_ready || !all_full_s;
        end
    end

    assign chain_valid_s[0] = src_valid_s;
    assign chain_data_s[0]  = perm_data_s;
    assign chain_mode_s[0]  = src_mode_s;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        des_perm_stage #(.WIDTH(W)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (chain_valid_s[s]),
            .in_data   (chain_data_s[s]),
            .in_mode   (chain_mode_s[s]),
            .out_valid (chain_valid_s[s+1]),
            .out_ready (ready_s[s+1]),
            .out_data  (chain_data_s[s+1]),
            .out_mode  (chain_mode_s[s+1])
        );
        assign v_s[s] = chain_valid_s[s+1];
    end

    assign out_valid = chain_valid_s[STAGES];
    assign out_data  = chain_data_s[STAGES];
    assign out_mode  = chain_mode_s[STAGES];
    assign busy      = |v_s;

    // Split each lane into its L and R halves
    always_comb begin
        out_l = '0;
        out_r = '0;
        for (int k = 0; k < LANES; k++) begin
            out_l[32*k +: 32] = out_data[64*k +: 32];
            out_r[32*k +: 32] = out_data[64*k+32 +: 32];
        end
    end

endmodule

// File: tb/tb_des_perm_pipe.sv
// Randomised self-checking bench for des_perm_pipe (LANES=2, STAGES=3) against a table model.
module tb_des_perm_pipe;

    localparam int LANES  = 2;
    localparam int STAGES = 3;
`ifdef DES_PERM_SKID_EN
    localparam int LAT = STAGES;
    localparam int CAP = STAGES + 2;
`else
    localparam int LAT = STAGES - 1;
    localparam int CAP = STAGES;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [0:127] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_mode;
    logic [0:127] out_data;
    logic [0:63]  out_l;
    logic [0:63]  out_r;
    logic         busy;

    int           ip_t [64];
    int           fp_t [64];
    logic [128:0] exp_q [$];
    int           out_cyc [$];
    int           acc_cyc [$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_acc   = 0;
    int           n_out   = 0;
    int           cyc     = 0;
    logic         hold_chk = 1'b0;
    logic [128:0] hold_val = '0;

    des_perm_pipe #(.LANES(LANES), .STAGES(STAGES)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_data  (out_data),
        .out_l     (out_l),
        .out_r     (out_r),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DES bit j (1-based) of a 64-bit word lives at x[64-j]
    function automatic logic [127:0] model(input logic [0:127] d, input logic m);
        logic [127:0] r;
        logic [63:0]  x;
        logic [63:0]  y;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            x = d[64*k +: 64];
            if (m) x = {x[31:0], x[63:32]};
            for (int i = 0; i < 64; i++) y[63-i] = x[64 - (m ? fp_t[i] : ip_t[i])];
            r[127-64*k -: 64] = y;
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        logic [128:0] e;
        @(negedge clk);
        if (hold_chk) begin
            check("hold_valid", out_valid, 1);
            check("hold_beat", {out_mode, out_data}, hold_val);
        end
        hold_chk = out_valid && !out_ready;
        hold_val = {out_mode, out_data};
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("beat", {out_mode, out_data}, e);
                check("halves", {out_l, out_r}, {e[127:96], e[63:32], e[95:64], e[31:0]});
                n_out++;
                out_cyc.push_back(cyc);
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back({in_mode, model(in_data, in_mode)});
            n_acc++;
            acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        for (int g = 0; g < 300 && exp_q.size() != 0; g++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int b0;
        int o0;
        int filled;
        logic [127:0] e128;

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                ip_t[8*r+c] = ((r < 4) ? (58 + 2*r) : (57 + 2*(r-4))) - 8*c;
        for (int i = 0; i < 64; i++) fp_t[ip_t[i]-1] = i + 1;

        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_lr", {out_l, out_r}, 0);
        check("rst_out_mode", out_mode, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        // known IP vector, latency from empty
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 1'b0;
        in_data = {64'h0123456789ABCDEF, 64'(rnd128())};
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check("ip_latency", lat, LAT);
        check("ip_data", out_data[0:63], 64'hCC00CCFFF0AAF0AA);
        check("ip_l", out_l[0:31], 32'hCC00CCFF);
        check("ip_r", out_r[0:31], 32'hF0AAF0AA);

        // known FP vector
        in_valid = 1'b1; in_mode = 1'b1;
        in_data = {64'hF0AAF0AACC00CCFF, 64'(rnd128())};
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check("fp_data", out_data[0:63], 64'h0123456789ABCDEF);
        check("fp_mode", out_mode, 1);
        drain();

        // 10 back-to-back beats
        b0 = n_acc; o0 = n_out;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_mode = 1'($urandom_range(0, 1)); in_data = rnd128();
            tick();
        end
        in_valid = 1'b0;
        drain();
        check("b2b_accepts", n_acc - b0, 10);
        check("b2b_count", n_out - o0, 10);
        if (n_out - o0 >= 10 && n_acc - b0 >= 10) begin
            check("b2b_latency", out_cyc[o0] - acc_cyc[b0], LAT + 1);
            check("b2b_gapless", out_cyc[o0+9] - out_cyc[o0], 9);
        end

        // backpressure with a full pipeline
        out_ready = 1'b0;
        b0 = n_acc;
        for (int g = 0; g < 20 && in_ready; g++) begin
            in_valid = 1'b1; in_mode = 1'($urandom_range(0, 1)); in_data = rnd128();
            tick();
        end
        in_valid = 1'b0;
        filled = n_acc - b0;
        check("bp_capacity", filled, CAP);
        for (int g = 0; g < 5; g++) begin
            tick();
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 1);
        end
        out_ready = 1'b1;
        #1;
`ifdef DES_PERM_SKID_EN
        check("bp_ready_registered", in_ready, 0);
`else
        check("bp_ready_comb", in_ready, 1);
`endif
        o0 = n_out;
        drain();
        check("bp_all_out", n_out - o0, filled);

        // reset with beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_mode = 1'($urandom_range(0, 1)); in_data = rnd128();
            tick();
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", out_data, 0);
        exp_q.delete();
        hold_chk = 1'b0;
        n_acc = n_out;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 1'b0;
        in_data = {64'h0000000000000001, 64'h0};
        e128 = model(in_data, 1'b0);
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check("post_rst_data", out_data[0:63], e128[127:64]);
        drain();

        // random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_mode   = 1'($urandom_range(0, 1));
            in_data   = rnd128();
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        check("conservation", n_out, n_acc);
        check("idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
